// File: rtl/bf_io_pkg.sv
// -----------------------------------------------------------------------------
// bf_io_pkg
//   Shared definitions for the Brainfuck core's byte I/O blocks. The UART
//   receiver uses them here, and the SFR transmitter reuses the same constants.
//
//   Contents:
//     rx_state_t      receiver FSM states (IDLE, START, DATA, STOP)
//     UART_DATA_BITS  data bits per 8N1 frame
//     DEFAULT_BAUD    default line rate in bit/s
//     clks_per_bit()  rounded number of clock cycles per bit
// -----------------------------------------------------------------------------
package bf_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int DEFAULT_BAUD   = 115200;

  // Round to the nearest whole number of clocks per bit, so that the
  // accumulated timing error over a frame stays as small as possible.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
//   Small show-ahead FIFO. The storage is a plain register array, so it maps to
//   distributed RAM. The head entry appears on rd_data combinationally whenever
//   the FIFO is non-empty. When the FIFO is empty, rd_data is all zeros.
//
//   Parameters:
//     DEPTH  number of entries (power of two, >= 2)
//     WIDTH  entry width in bits
//
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset (pointers and count cleared)
//     push       write push_data this cycle (ignored when full unless popping)
//     push_data  data to write
//     pop        consume the head entry (ignored when empty)
//     rd_data    head entry, or 0 when empty
//     full       count == DEPTH
//     empty      count == 0
//     count      number of entries held
//
//   Handshake: a push is accepted when !full, or when a pop also takes effect
//   in the same cycle. A pop is accepted when !empty. Both sides act on the
//   same rising edge. There is no back-pressure beyond full and empty.
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop on a full FIFO frees one slot in the same cycle, so a push that
  // arrives alongside it still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // The pointers wrap at DEPTH without extra logic, because DEPTH is a power
  // of two. The separate count tells full apart from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The storage has no reset. Stale entries are never visible, because
  // rd_data is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_input.sv
// -----------------------------------------------------------------------------
// uart_rx_input
//   8N1 UART receiver that feeds the Brainfuck core's ',' instruction. Bytes
//   received from the line are buffered in a show-ahead FIFO. The slower core
//   can then consume them whenever it is ready.
//
//   Parameters:
//     CLK_FREQ    clk frequency in Hz
//     BAUD        line rate in bit/s
//     FIFO_DEPTH  buffer entries (power of two, >= 2)
//
//   Ports:
//     clk         clock, rising edge
//     rst         synchronous active-high reset
//     rx          asynchronous serial input, idle high
//     rd_pop      single-cycle pulse; consumes the head byte
//     rd_data     head byte, or 8'h00 when empty
//     rd_valid    FIFO non-empty
//     fifo_count  bytes held
//     rx_busy     receiver FSM not in IDLE
//     overflow    sticky; a byte was dropped because the FIFO was full
//     frame_err   sticky; a stop bit sampled low
//     err_clr     pulse; clears overflow and frame_err (a new event wins)
//
//   Handshake (read side): rd_valid is the valid signal. rd_pop is treated as
//   ready only while rd_valid is high, and a pop while empty is ignored.
//   rd_data is valid in the same cycle as rd_valid. After a pop, the next head
//   byte appears one cycle later.
//
//   The internal signal 'state' (rx_state_t) holds the FSM state, so checkers
//   can bind to it directly.
// -----------------------------------------------------------------------------
module uart_rx_input
  import bf_io_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = DEFAULT_BAUD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_pop,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          overflow,
  output logic                          frame_err,
  input  logic                          err_clr
);

  localparam int DIV   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] RELOAD_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] RELOAD_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(UART_DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser. The flops reset to the idle level, so leaving reset
  // never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (rst) rx_sync <= 2'b11;
    else     rx_sync <= {rx_sync[0], rx};
  end

  assign rx_s = rx_sync[1];

  // ---------------------------------------------------------------------------
  // Receiver FSM, bit timer and shift register
  // ---------------------------------------------------------------------------
  rx_state_t                 state;
  logic [CNT_W-1:0]          bit_cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      cnt_zero;

  assign cnt_zero = (bit_cnt == '0);

  // Sampling starts HALF clocks after the falling edge is seen. After that, it
  // steps in whole bit periods, so every sample falls near the middle of a bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            bit_cnt <= RELOAD_HALF;
            state   <= START;
          end
        end

        START: begin
          if (cnt_zero) begin
            if (!rx_s) begin
              bit_cnt <= RELOAD_BIT;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              // The line went high again before mid-bit, so this was a glitch.
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        DATA: begin
          if (cnt_zero) begin
            // Bits arrive LSB first. Shifting in at the MSB leaves bit 0 in the
            // LSB once all eight bits are in.
            shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            bit_cnt <= RELOAD_BIT;
            if (bit_idx == LAST_IDX) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end

        STOP: begin
          if (cnt_zero) state <= IDLE;
          else          bit_cnt <= bit_cnt - 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // End-of-frame decodes. Both are valid only in the cycle the stop bit is
  // sampled.
  logic byte_done;
  logic stop_bad;

  assign byte_done = (state == STOP) && cnt_zero &&  rx_s;
  assign stop_bad  = (state == STOP) && cnt_zero && !rx_s;

  assign rx_busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Receive buffer
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (byte_done),
    .push_data (shreg),
    .pop       (rd_pop),
    .rd_data   (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_valid = !fifo_empty;

  // ---------------------------------------------------------------------------
  // Sticky error flags. A new error event wins over err_clr in the same cycle.
  // A full FIFO is never empty, so a pop alongside the push always frees a
  // slot, and nothing is dropped.
  // ---------------------------------------------------------------------------
  logic ov_evt;

  assign ov_evt = byte_done && fifo_full && !rd_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ov_evt)       overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;

      if (stop_bad)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_input.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_input
//   Self-checking bench for uart_rx_input. It runs with DIV=8, HALF=4 and a
//   4-entry FIFO. The expected FIFO contents and overflow flag come from a
//   queue model of the receiver's intended behaviour.
// -----------------------------------------------------------------------------
module tb_uart_rx_input;

  localparam int DIV   = 8;
  localparam int HALF  = 4;
  localparam int DEPTH = 4;
  // 2 synchroniser cycles, then half a bit to the start sample, then 9 bit
  // periods to the stop sample, then one cycle for the FIFO write.
  localparam int RISE_LAT = 2 + HALF + 9 * DIV + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_pop;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       rx_busy;
  logic       overflow;
  logic       frame_err;

  always #5 clk = ~clk;

  uart_rx_input #(
    .CLK_FREQ   (8),
    .BAUD       (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd_pop     (rd_pop),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .rx_busy    (rx_busy),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  int checks   = 0;
  int failures = 0;

  // Cycle counter, plus a monitor that records when rd_valid rises.
  int   cyc = 0;
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rd_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rd_valid;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  logic       exp_ov = 1'b0;

  task automatic model_rx(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      exp_ov = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) tick();
    end
    rx = stop;
    repeat (DIV) tick();
    rx = 1'b1;
  endtask

  task automatic pop_one();
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_ov  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd_pop = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    checks++; if (rd_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'h00)  begin failures++; $display("FAIL reset_data: got %h expected 00", rd_data); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (rx_busy !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_single();
    int start_cyc;
    rise_cyc  = -1;
    start_cyc = cyc;
    send_frame(8'h41, 1'b1);
    checks++; if (rise_cyc - start_cyc != RISE_LAT) begin failures++; $display("FAIL single_latency: got %0d expected %0d", rise_cyc - start_cyc, RISE_LAT); end
    checks++; if (rd_data !== 8'h41)   begin failures++; $display("FAIL single_data: got %h expected 41", rd_data); end
    checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    checks++; if (overflow !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL single_flags: got ovf=%b ferr=%b expected 0 0", overflow, frame_err); end
    pop_one();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL single_pop_data: got %h expected 00", rd_data); end
    idle(4);
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (2) tick();
    rx = 1'b1;
    repeat (4) tick();
    // The synchroniser delays the low by two cycles. The start check then
    // falls HALF cycles after the low is seen, so the FSM is in START until
    // this cycle.
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_before: got %b expected 1", rx_busy); end
    tick();
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_after: got %b expected 0", rx_busy); end
    idle(10);
    checks++; if (rd_valid !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL glitch_state: got valid=%b ferr=%b expected 0 0", rd_valid, frame_err); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0);
    idle(16);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
    checks++; if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL ferr_fifo: got valid=%b count=%0d expected 0 0", rd_valid, fifo_count); end
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_busy: got %b expected 0", rx_busy); end
    clear_errors();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      model_rx(8'(i));
      idle(4);
    end
    checks++; if (fifo_count !== 3'(exp_q.size())) begin failures++; $display("FAIL ovf_count: got %0d expected %0d", fifo_count, exp_q.size()); end
    checks++; if (overflow !== exp_ov) begin failures++; $display("FAIL ovf_flag: got %b expected %b", overflow, exp_ov); end
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++; if (rd_data !== e) begin failures++; $display("FAIL ovf_order: got %h expected %h", rd_data, e); end
      pop_one();
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained: got %b expected 0", rd_valid); end
    clear_errors();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] last;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1);
      model_rx(8'(i));
      idle(4);
    end
    // The stop bit of 0x06 is sampled RISE_LAT-1 cycles after the start bit
    // is driven. Popping in that same cycle makes the pop coincide with the
    // push.
    fork
      send_frame(8'h06, 1'b1);
      begin
        repeat (RISE_LAT - 1) tick();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    model_rx(8'h06);
    idle(2);
    checks++; if (fifo_count !== 3'(exp_q.size())) begin failures++; $display("FAIL b2b_count: got %0d expected %0d", fifo_count, exp_q.size()); end
    checks++; if (overflow !== exp_ov) begin failures++; $display("FAIL b2b_ovf: got %b expected %b", overflow, exp_ov); end
    last = 8'h00;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++; if (rd_data !== e) begin failures++; $display("FAIL b2b_order: got %h expected %h", rd_data, e); end
      last = rd_data;
      pop_one();
    end
    checks++; if (last !== 8'h06) begin failures++; $display("FAIL b2b_last: got %h expected 06", last); end
    clear_errors();
  endtask

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [7:0] b;
      int         npop;
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      model_rx(b);
      idle(4);
      checks++; if (fifo_count !== 3'(exp_q.size())) begin failures++; $display("FAIL rand_count: got %0d expected %0d", fifo_count, exp_q.size()); end
      checks++; if (overflow !== exp_ov) begin failures++; $display("FAIL rand_ovf: got %b expected %b", overflow, exp_ov); end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        checks++; if (rd_data !== e) begin failures++; $display("FAIL rand_data: got %h expected %h", rd_data, e); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pop_one();
      end
    end
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++; if (rd_data !== e) begin failures++; $display("FAIL rand_drain: got %h expected %h", rd_data, e); end
      pop_one();
    end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rand_empty: got %b expected 0", rd_valid); end
    clear_errors();
  endtask

  task automatic test_mid_reset();
    logic [7:0] a5;
    // Leave a byte in the FIFO and set frame_err, so that reset has state to
    // clear.
    send_frame(8'h77, 1'b1);
    idle(4);
    send_frame(8'h55, 1'b0);
    idle(16);
    a5 = 8'hA5;
    rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 4; i++) begin
      rx = a5[i];
      repeat (DIV) tick();
    end
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b expected 1", rx_busy); end
    rst = 1'b1;
    rx  = 1'b1;
    tick();
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_count !== 3'd0) begin failures++; $display("FAIL mid_rst_fifo: got valid=%b data=%h count=%0d expected 0 00 0", rd_valid, rd_data, fifo_count); end
    checks++; if (rx_busy !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL mid_rst_flags: got busy=%b ovf=%b ferr=%b expected 0 0 0", rx_busy, overflow, frame_err); end
    repeat (2) tick();
    rst = 1'b0;
    idle(20);
    send_frame(8'h3C, 1'b1);
    idle(4);
    checks++; if (fifo_count !== 3'd1 || rd_data !== 8'h3C) begin failures++; $display("FAIL mid_recv: got count=%0d data=%h expected 1 3c", fifo_count, rd_data); end
    pop_one();
    checks++; if (rd_valid !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL mid_after: got valid=%b ferr=%b expected 0 0", rd_valid, frame_err); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overflow();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_input.md
# uart_rx_input

Byte-stream receiver that supplies the Brainfuck core's `,` (input) instruction. It deserialises an asynchronous 8N1 UART line into bytes and buffers them in a show-ahead FIFO, so the slow, divided-clock core can consume input at its own pace. It is the receive counterpart of the SFR UART transmitter and runs in the fast `clk` domain alongside the SFR block.

## Interface
- `CLK_FREQ`, 50_000_000: `clk` frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `FIFO_DEPTH`, 16: buffer entries; must be a power of two, ≥2.
- `DIV` (localparam): `(CLK_FREQ + BAUD/2) / BAUD`, clocks per bit. `HALF` = `DIV/2`.

Ports:
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rx`  in  1: asynchronous serial input, idle high.
- `rd_pop`  in  1: single-cycle pulse; consumes the head byte.
- `rd_data`  out  8: head byte; `8'h00` when empty.
- `rd_valid`  out  1: FIFO non-empty.
- `fifo_count`  out  `$clog2(FIFO_DEPTH)+1`: bytes held.
- `rx_busy`  out  1: receiver FSM not in IDLE.
- `overflow`  out  1: sticky; a byte was dropped because the FIFO was full.
- `frame_err`  out  1: sticky; the stop bit sampled low.
- `err_clr`  in  1: pulse; clears `overflow` and `frame_err`.

## Operation
- `rx` passes through a 2-FF synchroniser whose flops reset to 1. All logic uses the synchronised value `rx_s`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `rx_s==0`, load `bit_cnt=HALF-1` and go to START.
  - START: when the counter expires, sample `rx_s`. If 0, go to DATA with `bit_cnt=DIV-1` and `bit_idx=0`. If 1, treat it as a glitch and return to IDLE with no flags set.
  - DATA: on each counter expiry, shift `rx_s` into the MSB of the shift register (LSB-first on the wire) and reload `DIV-1`. After the 8th sample, go to STOP.
  - STOP: on expiry, sample `rx_s`. If 1, push the byte. If 0, set `frame_err` and discard the byte. Go to IDLE in both cases; a new start bit is accepted from the next cycle.
- Push when full: drop the byte and set `overflow`. FIFO contents are unchanged.
- Pop: `rd_pop` while `rd_valid` advances the read pointer. `rd_pop` while empty is ignored.
- Push and pop in the same cycle, FIFO non-empty: both take effect and `fifo_count` is unchanged. This also holds when full: the pop frees space, so no overflow.
- Push and pop in the same cycle, FIFO empty: the pop is ignored and the push lands.
- `err_clr` in the same cycle as a new error event: the set wins.
- Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. `fifo_count` is a separate counter.

## Timing
- Let t0 be the first cycle in which `rx_s==0` in IDLE. The start bit is sampled at t0+HALF.
- Data bit i (0..7) is sampled at t0+HALF+(i+1)·DIV.
- The stop bit is sampled at t0+HALF+9·DIV. The pushed byte is visible on `rd_valid`/`rd_data`/`fifo_count` at t0+HALF+9·DIV+1.
- `rd_data` shows the head byte combinationally, with zero latency, once `rd_valid` is high. After `rd_pop` at cycle t, the next head byte (or `8'h00`) appears at t+1.
- Reset, including mid-frame, gives:
  - FSM in IDLE, counters 0, FIFO empty;
  - `rd_valid=0`, `rd_data=8'h00`, `fifo_count=0`, `rx_busy=0`, `overflow=0`, `frame_err=0`;
  - synchroniser flops =1.
  - A frame in progress is lost. After reset, the receiver resynchronises on the next falling edge.

## Structure
- Package `bf_io_pkg` holds:
  - `rx_state_t` enum {IDLE, START, DATA, STOP};
  - the shared UART constants `UART_DATA_BITS=8` and the default `BAUD`, for reuse by the SFR transmitter.
- Sub-module `byte_fifo`:
  - parameters `DEPTH` and `WIDTH`;
  - show-ahead output, `push`/`pop`/`full`/`empty`/`count`;
  - synchronous reset; distributed-RAM array.
- The top of `uart_rx_input` contains the synchroniser, bit counter, FSM and error flags.

## Test plan
Benches use `CLK_FREQ=8`, `BAUD=1` (DIV=8, HALF=4) and `FIFO_DEPTH=4`.
- Send 0x41 → `rd_valid` rises at t0+77, `rd_data=0x41`, `fifo_count=1`, no flags. Then `rd_pop` → `rd_valid=0`, `rd_data=0x00`.
- Drive `rx` low for 2 cycles only → FSM returns to IDLE at t0+4, FIFO empty, `frame_err=0`.
- Send 0x55 with the stop bit held low → `frame_err=1`, FIFO empty. Then `err_clr` → `frame_err=0`.
- Send 5 bytes 0x01..0x05 without popping → `fifo_count=4`, `overflow=1`. Popping returns 0x01..0x04 in order.
- With the FIFO full, pulse `rd_pop` in the exact cycle 0x06 is pushed → `fifo_count` stays 4, `overflow` stays 0, and the last popped byte is 0x06.
- Assert `rst` mid-DATA of 0xA5, then send 0x3C → only 0x3C is received, and every output is at its reset value during `rst`.
